// File: rtl/wb_src_pkg.sv
// wb_src_pkg: shared types and constants for the write-back source sequencer.
//   state_t    : FSM state encoding (IDLE/WAIT/WRITE/ERR)
//   WB_*       : write-back class codes, also used as the mux selector value
//   needs_wait : true for classes whose data comes from a multi-cycle producer
package wb_src_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  localparam logic [2:0] WB_ALU     = 3'd0;
  localparam logic [2:0] WB_HI      = 3'd1;
  localparam logic [2:0] WB_LO      = 3'd2;
  localparam logic [2:0] WB_MEM     = 3'd3;
  localparam logic [2:0] WB_SHIFT   = 3'd4;
  localparam logic [2:0] WB_LUI     = 3'd5;
  localparam logic [2:0] WB_LINK    = 3'd6;
  localparam logic [2:0] WB_ILLEGAL = 3'd7;

  // HI/LO come from the mult/div unit, MEM from the memory port.
  function automatic logic needs_wait(input logic [2:0] wb_class);
    case (wb_class)
      WB_HI, WB_LO, WB_MEM: needs_wait = 1'b1;
      default:              needs_wait = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_wait_timer.sv
// wb_wait_timer: wait-cycle counter with synchronous clear and enable.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : clear counter to 0 (has priority over en)
//   en           : increment once per cycle while below MAX_WAIT
//   tc           : terminal count, high while count == MAX_WAIT
module wb_wait_timer #(
  parameter int MAX_WAIT = 40,
  parameter int CNT_W    = 6
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] count_r;

  // Wait counter; saturates at the terminal value so it can never wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && !tc) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == TC_VAL);

endmodule

// File: rtl/wb_src_ctrl.sv
// wb_src_ctrl: write-back source sequencer for the multicycle core.
// Accepts one write-back request in IDLE, drives the register-write-data mux
// selector, waits on memory / mult-div where needed and then strobes the
// register-bank write enable. Illegal classes and stuck producers pulse error.
//   clk, reset_n         : clock, asynchronous active-low reset
//   start                : request strobe (only looked at in IDLE)
//   wb_class, dest_reg   : source class and destination register of the request
//   mem_ready            : memory read data valid (class MEM)
//   muldiv_done          : mult/div result valid (classes HI, LO)
//   selector, reg_addr   : captured mux select / write address (registered)
//   reg_write            : one-cycle write strobe, suppressed for $zero
//   busy, done, error    : status (all registered)
module wb_src_ctrl
  import wb_src_pkg::*;
#(
  parameter int MAX_WAIT = 40,
  parameter int CNT_W    = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] wb_class,
  input  logic [4:0] dest_reg,
  input  logic       mem_ready,
  input  logic       muldiv_done,
  output logic [2:0] selector,
  output logic       reg_write,
  output logic [4:0] reg_addr,
  output logic       busy,
  output logic       done,
  output logic       error
);

  state_t state_r;
  logic   ready_s;
  logic   tc_s;
  logic   in_wait_s;

  assign in_wait_s = (state_r == ST_WAIT);

  // Counter is held at zero outside WAIT, so it reads 0 on the first WAIT cycle.
  wb_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!in_wait_s),
    .en      (in_wait_s),
    .tc      (tc_s)
  );

  // Pick the ready input that belongs to the captured class; the other is ignored.
  always_comb begin
    ready_s = 1'b0;
    case (selector)
      WB_MEM:       ready_s = mem_ready;
      WB_HI, WB_LO: ready_s = muldiv_done;
      default:      ready_s = 1'b0;
    endcase
  end

  // Sequencer FSM with capture registers and registered strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      selector  <= 3'b000;
      reg_addr  <= 5'd0;
      reg_write <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      reg_write <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            selector <= wb_class;
            reg_addr <= dest_reg;
            busy     <= 1'b1;
            if (wb_class == WB_ILLEGAL) begin
              state_r <= ST_ERR;
              error   <= 1'b1;
            end else if (needs_wait(wb_class)) begin
              state_r <= ST_WAIT;
            end else begin
              state_r   <= ST_WRITE;
              reg_write <= (dest_reg != 5'd0);
              done      <= 1'b1;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ST_WAIT: begin
          // Ready takes priority over the timeout on the terminal cycle.
          if (ready_s) begin
            state_r   <= ST_WRITE;
            reg_write <= (reg_addr != 5'd0);
            done      <= 1'b1;
          end else if (tc_s) begin
            state_r <= ST_ERR;
            error   <= 1'b1;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_WRITE, ST_ERR: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_src_ctrl.sv
module tb_wb_src_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [2:0] wb_class;
  logic [4:0] dest_reg;
  logic       mem_ready;
  logic       muldiv_done;
  logic [2:0] selector;
  logic       reg_write;
  logic [4:0] reg_addr;
  logic       busy;
  logic       done;
  logic       error;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  wb_src_ctrl #(.MAX_WAIT(40), .CNT_W(6)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .wb_class    (wb_class),
    .dest_reg    (dest_reg),
    .mem_ready   (mem_ready),
    .muldiv_done (muldiv_done),
    .selector    (selector),
    .reg_write   (reg_write),
    .reg_addr    (reg_addr),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (reg_write) wr_cnt++;
    if (done) done_cnt++;
    if (error) err_cnt++;
  end

  typedef struct {
    logic [2:0] cls;
    logic [4:0] dest;
    logic       exp_we;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a start for one cycle; returns positioned in cycle n+1.
  task automatic issue(input logic [2:0] c, input logic [4:0] d);
    wb_class = c;
    dest_reg = d;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_sel"}, int'(selector), 0);
    chk({tag, "_addr"}, int'(reg_addr), 0);
    chk({tag, "_we"}, int'(reg_write), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(error), 0);
  endtask

  initial begin
    int w0, d0, e0;
    reset_n = 1'b0; start = 1'b0; wb_class = 3'd0; dest_reg = 5'd0;
    mem_ready = 1'b0; muldiv_done = 1'b0;
    vecs[0] = '{3'd0, 5'd8,  1'b1, 1'b1, 1'b0};
    vecs[1] = '{3'd4, 5'd17, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{3'd5, 5'd31, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{3'd6, 5'd0,  1'b0, 1'b1, 1'b0};
    vecs[4] = '{3'd7, 5'd12, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{3'd6, 5'd3,  1'b1, 1'b1, 1'b0};
    step(); step();
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    step();

    // Immediate and illegal classes from the table.
    foreach (vecs[i]) begin
      issue(vecs[i].cls, vecs[i].dest);
      chk($sformatf("v%0d_sel", i), int'(selector), int'(vecs[i].cls));
      chk($sformatf("v%0d_addr", i), int'(reg_addr), int'(vecs[i].dest));
      chk($sformatf("v%0d_we", i), int'(reg_write), int'(vecs[i].exp_we));
      chk($sformatf("v%0d_done", i), int'(done), int'(vecs[i].exp_done));
      chk($sformatf("v%0d_err", i), int'(error), int'(vecs[i].exp_err));
      chk($sformatf("v%0d_busy1", i), int'(busy), 1);
      step();
      chk($sformatf("v%0d_busy2", i), int'(busy), 0);
      chk($sformatf("v%0d_we2", i), int'(reg_write), 0);
      chk($sformatf("v%0d_sel_hold", i), int'(selector), int'(vecs[i].cls));
    end

    // MEM class: mem_ready in n+4 -> write in n+5; muldiv_done ignored.
    w0 = wr_cnt;
    issue(3'd3, 5'd9);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("mem_sel_c%0d", k), int'(selector), 3);
      chk($sformatf("mem_we_c%0d", k), int'(reg_write), 0);
      chk($sformatf("mem_busy_c%0d", k), int'(busy), 1);
      muldiv_done = (k == 2);
      mem_ready   = (k == 4);
      step();
    end
    mem_ready = 1'b0; muldiv_done = 1'b0;
    chk("mem_we", int'(reg_write), 1);
    chk("mem_done", int'(done), 1);
    chk("mem_addr", int'(reg_addr), 9);
    chk("mem_sel", int'(selector), 3);
    step();
    chk("mem_busy_end", int'(busy), 0);
    step();
    chk("mem_write_count", wr_cnt - w0, 1);

    // Timeout on HI: error at n+42, idle at n+43.
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    issue(3'd1, 5'd5);
    for (int k = 1; k <= 41; k++) begin
      if (error !== 1'b0 || busy !== 1'b1) chk($sformatf("to_early_c%0d", k), int'({error, busy}), 1);
      step();
    end
    chk("to_err", int'(error), 1);
    chk("to_done", int'(done), 0);
    chk("to_we", int'(reg_write), 0);
    chk("to_busy", int'(busy), 1);
    step();
    chk("to_busy_end", int'(busy), 0);
    chk("to_err_end", int'(error), 0);
    chk("to_counts", (wr_cnt - w0) * 100 + (done_cnt - d0) * 10 + (err_cnt - e0), 1);

    // Ready on the terminal cycle wins over timeout.
    e0 = err_cnt;
    issue(3'd2, 5'd7);
    for (int k = 1; k <= 40; k++) step();
    muldiv_done = 1'b1;
    step();
    muldiv_done = 1'b0;
    chk("term_we", int'(reg_write), 1);
    chk("term_done", int'(done), 1);
    chk("term_err", int'(error), 0);
    step();
    chk("term_busy_end", int'(busy), 0);
    chk("term_err_count", err_cnt - e0, 0);

    // Second start during WAIT is ignored.
    w0 = wr_cnt;
    issue(3'd3, 5'd10);
    wb_class = 3'd0; dest_reg = 5'd20; start = 1'b1;
    step();
    start = 1'b0;
    chk("dbl_sel", int'(selector), 3);
    chk("dbl_addr", int'(reg_addr), 10);
    chk("dbl_we", int'(reg_write), 0);
    chk("dbl_busy", int'(busy), 1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("dbl_we2", int'(reg_write), 1);
    chk("dbl_addr2", int'(reg_addr), 10);
    step(); step(); step();
    chk("dbl_write_count", wr_cnt - w0, 1);
    chk("dbl_busy_end", int'(busy), 0);

    // Reset in WAIT: immediate return to reset values, nothing afterwards.
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    issue(3'd2, 5'd11);
    step();
    chk("rst_pre_busy", int'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("rst_mid");
    step(); step();
    reset_n = 1'b1;
    muldiv_done = 1'b1;
    step(); step(); step();
    muldiv_done = 1'b0;
    chk("rst_post_busy", int'(busy), 0);
    chk("rst_post_counts", (wr_cnt - w0) * 100 + (done_cnt - d0) * 10 + (err_cnt - e0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_src_ctrl.md
# wb_src_ctrl

Write-back source sequencer for the multicycle core. It takes one write-back request per instruction from the main control unit and drives the 3-bit selector of the 7:1 32-bit register-write-data mux. It waits on multi-cycle producers (memory, mult/div) before strobing the register-bank write enable. Bad requests and stuck producers are reported through a timeout/error path.

## Interface

Parameters:
- MAX_WAIT, default 40: max cycles spent waiting on a producer before error (≥ divider latency 33).
- CNT_W, default 6: width of wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only in IDLE
- wb_class  in  3  source code: 0 ALU, 1 HI, 2 LO, 3 MEM data, 4 shifter, 5 LUI imm, 6 PC+4 link; 7 illegal
- dest_reg  in  5  destination register index
- mem_ready  in  1  memory read data valid (class 3)
- muldiv_done  in  1  mult/div result valid (classes 1, 2)
- selector  out  3  mux select, registered
- reg_write  out  1  register-bank write enable, one-cycle pulse
- reg_addr  out  5  write address, registered
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse on completion (with or without write)
- error  out  1  one-cycle pulse on illegal class or timeout

## Operation

- States: IDLE, WAIT, WRITE, ERR.
- IDLE + start:
  - Capture wb_class into selector and dest_reg into reg_addr.
  - Class 7 → ERR.
  - Class 1, 2, 3 → WAIT.
  - Else → WRITE.
- start outside IDLE: ignored, with no effect on captured values.
- WAIT:
  - The counter clears on entry and increments each WAIT cycle.
  - The relevant ready input (mem_ready for class 3, muldiv_done for 1/2) high → WRITE. The other ready input is ignored.
  - Counter == MAX_WAIT with ready low → ERR.
  - Ready high in the same cycle as counter == MAX_WAIT: ready wins, go to WRITE.
- WRITE:
  - reg_write = 1 unless reg_addr == 0; a $zero write is suppressed.
  - done = 1.
  - Next state IDLE.
- ERR: error = 1, done = 0, no write; next state IDLE.
- selector and reg_addr hold their captured values until the next accepted start, so the mux output is stable through WAIT and WRITE.
- Reset values:
  - state IDLE, counter 0.
  - selector 3'b000, reg_addr 0.
  - reg_write 0, busy 0, done 0, error 0.
- Reset asserted mid-operation: immediate return to reset values; the pending write is dropped, with no done and no error.

## Timing

- start high in cycle n (IDLE): selector and reg_addr valid and busy = 1 from cycle n+1.
- Immediate classes (0, 4, 5, 6): WRITE in n+1 (reg_write, done). IDLE in n+2, where start is accepted again. Throughput: one request per 2 cycles.
- Wait classes: WAIT from n+1. Ready sampled high in cycle m → WRITE in m+1, IDLE in m+2.
- Timeout: ready never high → counter hits MAX_WAIT in cycle n+1+MAX_WAIT → ERR in n+2+MAX_WAIT, IDLE the cycle after.
- Illegal class: ERR in n+1, IDLE in n+2.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure

- Package wb_src_pkg:
  - State encoding: IDLE=2'd0, WAIT=2'd1, WRITE=2'd2, ERR=2'd3.
  - Class constants WB_ALU … WB_LINK, WB_ILLEGAL=3'd7.
  - Helper function needs_wait(class).
- One sub-module, wb_wait_timer: clear/enable counter with a terminal-count flag at MAX_WAIT; same clk/reset_n.
- Top: FSM plus capture registers.

## Test plan

- Reset, then start with wb_class=0, dest_reg=8 → cycle n+1: selector=0, reg_addr=8, reg_write=1, done=1; n+2 busy=0.
- wb_class=3, dest_reg=9, mem_ready raised 4 cycles after start → reg_write pulses exactly once, one cycle after mem_ready; selector=3 held throughout WAIT.
- wb_class=1, muldiv_done never raised, MAX_WAIT=40 → error pulse at n+42, no reg_write, no done, busy drops at n+43; then muldiv_done arriving on the terminal cycle → WRITE taken, no error.
- wb_class=6, dest_reg=0 → done=1, reg_write=0; wb_class=7 → error=1 at n+1, no done.
- Second start during WAIT with different class/dest → ignored; selector/reg_addr unchanged and only the first write occurs.
- reset_n pulled low in WAIT (class 2) → all outputs to reset values immediately; after release, no stray write or done.
